wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter between the pipeline and a
// multdiv unit. Pipeline writes always win; multdiv results wait in a small
// FIFO and drain on cycles the pipeline leaves free. When the FIFO has waited
// too long, wb_hold asks the pipeline for one bubble.
//
// Parameters:
//   DEPTH       multdiv result buffer entries (power of two, 2..8)
//   STARVE_MAX  non-draining cycles before wb_hold asserts (1..15)
//
// Ports:
//   clock, ctrl_reset_n                  clock, async active-low reset
//   wb_valid, wb_reg, wb_data            pipeline writeback request
//   md_valid, md_ready, md_reg, md_data  multdiv result handshake
//   rd_regA, rd_regB, raw_stall          decode-stage hazard check
//   wb_hold                              pipeline bubble request
//   ctrl_writeEnable, ctrl_writeReg,
//   data_writeReg                        registered register-file write port
//
// Optional feature: define WB_ARB_BYPASS_EN to let a multdiv result skip the
// empty buffer on an otherwise idle cycle (1-cycle latency).

module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic [4:0]  rd_regA,
  input  logic [4:0]  rd_regB,
  output logic        raw_stall,
  output logic        wb_hold,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [3:0]    STARVE_C = 4'(STARVE_MAX);

  logic [4:0]       reg_mem_q  [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       starve_q, starve_d;
  logic             we_q, we_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;

  logic pipe_wr, md_take, bypass, push, pop;
  logic hit_a, hit_b;

  // md_ready looks only at current occupancy, never at a same-cycle pop,
  // so a full buffer always refuses for at least one cycle.
  assign md_ready = ctrl_reset_n && (count_q < DEPTH_C);
  assign pipe_wr  = wb_valid && (wb_reg != 5'd0);
  // Writes to r0 are accepted and dropped on the floor.
  assign md_take  = md_valid && md_ready && (md_reg != 5'd0);
  assign pop      = !pipe_wr && (count_q != '0);

`ifdef WB_ARB_BYPASS_EN
  assign bypass = md_take && (count_q == '0) && !pipe_wr;
`else
  assign bypass = 1'b0;
`endif

  assign push = md_take && !bypass;

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (pipe_wr) begin
      we_d    = 1'b1;
      wreg_d  = wb_reg;
      wdata_d = wb_data;
    end else if (pop) begin
      we_d    = 1'b1;
      wreg_d  = reg_mem_q[rd_ptr_q];
      wdata_d = data_mem_q[rd_ptr_q];
    end else if (bypass) begin
      we_d    = 1'b1;
      wreg_d  = md_reg;
      wdata_d = md_data;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Saturating wait counter; an empty buffer or any drain resets it.
  always_comb begin
    starve_d = starve_q;
    if ((count_q == '0) || pop) starve_d = 4'd0;
    else if (starve_q != 4'hF)  starve_d = starve_q + 4'd1;
  end

  assign wb_hold = (starve_q >= STARVE_C);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= 4'd0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Entry storage needs no reset; valid_q qualifies every read.
  always_ff @(posedge clock) begin
    if (push) begin
      reg_mem_q[wr_ptr_q]  <= md_reg;
      data_mem_q[wr_ptr_q] <= md_data;
    end
  end

  // A source is stale if it is still buffered, or issued last edge and not
  // yet readable from the register file.
  always_comb begin
    hit_a = we_q && (wreg_q == rd_regA);
    hit_b = we_q && (wreg_q == rd_regB);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (reg_mem_q[i] == rd_regA)) hit_a = 1'b1;
      if (valid_q[i] && (reg_mem_q[i] == rd_regB)) hit_b = 1'b1;
    end
  end

  assign raw_stall = ((rd_regA != 5'd0) && hit_a) || ((rd_regB != 5'd0) && hit_b);

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clock;
  logic        ctrl_reset_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic [4:0]  rd_regA;
  logic [4:0]  rd_regB;
  logic        raw_stall;
  logic        wb_hold;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .wb_valid         (wb_valid),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_reg           (md_reg),
    .md_data          (md_data),
    .rd_regA          (rd_regA),
    .rd_regB          (rd_regB),
    .raw_stall        (raw_stall),
    .wb_hold          (wb_hold),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: pending multdiv results as a plain queue, plus the
  // write the register file is about to see and a wait counter.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_starve;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_raw(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_we && m_wreg == r) return 1'b1;
    foreach (mq[i]) if (mq[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we     = 1'b0;
    m_wreg   = 5'd0;
    m_wdata  = 32'd0;
    m_starve = 0;
  endtask

  // Check the DUT against the model, advance the model by one clock using
  // the currently driven inputs, then step the clock.
  task automatic tick();
    bit pipe, acc, pop, byp;
    int occ;
    #1;
    occ = mq.size();
    chk("md_ready",  32'(md_ready),  32'(occ < DEPTH));
    chk("raw_stall", 32'(raw_stall), 32'(m_raw(rd_regA) || m_raw(rd_regB)));
    chk("wb_hold",   32'(wb_hold),   32'(m_starve >= STARVE_MAX));
    chk("we",        32'(ctrl_writeEnable), 32'(m_we));
    chk("wreg",      32'(ctrl_writeReg),    32'(m_wreg));
    chk("wdata",     data_writeReg,         m_wdata);

    pipe = wb_valid && (wb_reg != 5'd0);
    acc  = md_valid && (occ < DEPTH);
    pop  = !pipe && (occ > 0);
`ifdef WB_ARB_BYPASS_EN
    byp  = acc && (md_reg != 5'd0) && (occ == 0) && !pipe;
`else
    byp  = 1'b0;
`endif
    if (occ == 0 || pop) m_starve = 0;
    else if (m_starve < 15) m_starve = m_starve + 1;

    if (pipe) begin
      m_we = 1'b1; m_wreg = wb_reg; m_wdata = wb_data;
    end else if (pop) begin
      m_we = 1'b1; m_wreg = mq[0].r; m_wdata = mq[0].d;
    end else if (byp) begin
      m_we = 1'b1; m_wreg = md_reg; m_wdata = md_data;
    end else begin
      m_we = 1'b0;
    end
    if (pop) void'(mq.pop_front());
    if (acc && md_reg != 5'd0 && !byp) mq.push_back('{r: md_reg, d: md_data});

    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
    rd_regA  = 5'd0; rd_regB = 5'd0;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    chk("rst_we",     32'(ctrl_writeEnable), 32'd0);
    chk("rst_wreg",   32'(ctrl_writeReg),    32'd0);
    chk("rst_wdata",  data_writeReg,         32'd0);
    chk("rst_ready",  32'(md_ready),         32'd0);
    chk("rst_hold",   32'(wb_hold),          32'd0);
    chk("rst_raw",    32'(raw_stall),        32'd0);
    #10;
    ctrl_reset_n = 1'b1;
    tick();

    // Plain pipeline write.
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h0000_00AA;
    tick();
    chk("pipe_we",    32'(ctrl_writeEnable), 32'd1);
    chk("pipe_wreg",  32'(ctrl_writeReg),    32'd5);
    chk("pipe_wdata", data_writeReg,         32'h0000_00AA);
    idle_inputs();
    tick();
    chk("idle_we",    32'(ctrl_writeEnable), 32'd0);
    chk("idle_hold",  data_writeReg,         32'h0000_00AA);

    // Collision: pipeline r3 wins, multdiv r7 follows one cycle later.
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h11;
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h22;
    rd_regA  = 5'd7;
    tick();
    chk("col_wreg1",  32'(ctrl_writeReg), 32'd3);
    chk("col_raw1",   32'(raw_stall),     32'd1);
    wb_valid = 1'b0; md_valid = 1'b0;
    tick();
    chk("col_wreg2",  32'(ctrl_writeReg), 32'd7);
    chk("col_wdata2", data_writeReg,      32'h22);
    chk("col_raw2",   32'(raw_stall),     32'd1);
    tick();
    chk("col_raw3",   32'(raw_stall),     32'd0);
    idle_inputs();

    // Full buffer under continuous pipeline traffic.
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'hCAFE_0001;
    md_valid = 1'b1; md_reg = 5'd10; md_data = 32'hA0;
    tick();
    md_reg = 5'd11; md_data = 32'hA1;
    tick();
    chk("full_ready", 32'(md_ready), 32'd0);
    md_reg = 5'd12; md_data = 32'hA2;
    for (int i = 0; i < 3; i++) tick();
    chk("full_hold",  32'(wb_hold),  32'd1);
    wb_valid = 1'b0;
    tick();
    chk("drain_wreg", 32'(ctrl_writeReg), 32'd10);
    chk("drain_hold", 32'(wb_hold),       32'd0);
    md_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // r0 from both sources is swallowed.
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
    md_valid = 1'b1; md_reg = 5'd0; md_data = 32'hFFFF_FFFF;
    tick();
    chk("zero_we",    32'(ctrl_writeEnable), 32'd0);
    chk("zero_ready", 32'(md_ready),         32'd1);
    idle_inputs();
    tick();
    chk("zero_we2",   32'(ctrl_writeEnable), 32'd0);

    // Reset with two results queued.
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h55;
    md_valid = 1'b1; md_reg = 5'd20; md_data = 32'h20;
    tick();
    md_reg = 5'd21; md_data = 32'h21;
    rd_regA = 5'd20;
    tick();
    idle_inputs();
    rd_regA = 5'd20; rd_regB = 5'd21;
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    chk("mrst_we",    32'(ctrl_writeEnable), 32'd0);
    chk("mrst_wreg",  32'(ctrl_writeReg),    32'd0);
    chk("mrst_wdata", data_writeReg,         32'd0);
    chk("mrst_ready", 32'(md_ready),         32'd0);
    chk("mrst_hold",  32'(wb_hold),          32'd0);
    chk("mrst_raw",   32'(raw_stall),        32'd0);
    model_reset();
    @(posedge clock);
    #3;
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_noissue", 32'(ctrl_writeEnable), 32'd0);
    end
    idle_inputs();

    // Idle multdiv result: bypass timing depends on the build option.
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h1234;
    tick();
    md_valid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    chk("byp_we",     32'(ctrl_writeEnable), 32'd1);
    chk("byp_wreg",   32'(ctrl_writeReg),    32'd9);
`else
    chk("nobyp_we0",  32'(ctrl_writeEnable), 32'd0);
    tick();
    chk("nobyp_we1",  32'(ctrl_writeEnable), 32'd1);
    chk("nobyp_wreg", 32'(ctrl_writeReg),    32'd9);
`endif
    chk("md_wdata",   data_writeReg,         32'h1234);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      wb_valid = ($urandom_range(0, 99) < 55);
      wb_reg   = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      md_valid = ($urandom_range(0, 99) < 50);
      md_reg   = 5'($urandom_range(0, 7));
      md_data  = $urandom;
      rd_regA  = 5'($urandom_range(0, 7));
      rd_regB  = 5'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
